// File: rtl/fmul_result_packer.sv
// Custom-float multiplier output stage: special-case resolve,
// 24-bit pack, 2-entry output FIFO, sticky flags, result count.
module fmul_result_packer #(
  parameter bit SAT_MODE = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [6:0]       in_exp,
  input  logic [15:0]      in_mantissa,
  input  logic             in_overflow,
  input  logic             in_underflow,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_data,
  output logic [2:0]       out_flags,
  input  logic             clr_sticky,
  output logic             sticky_overflow,
  output logic             sticky_underflow,
  output logic [CNT_W-1:0] result_count
);

  localparam logic [2:0] F_OVF  = 3'b100;
  localparam logic [2:0] F_UNF  = 3'b010;
  localparam logic [2:0] F_ZERO = 3'b001;

  logic [23:0] pk_data;
  logic [2:0]  pk_flags;

  logic [23:0] head_data_q, head_data_d;
  logic [2:0]  head_flags_q, head_flags_d;
  logic [23:0] tail_data_q, tail_data_d;
  logic [2:0]  tail_flags_q, tail_flags_d;
  logic [1:0]  count_q, count_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        sticky_ovf_q, sticky_ovf_d;
  logic        sticky_unf_q, sticky_unf_d;
  logic [CNT_W-1:0] result_count_q, result_count_d;

  logic push;
  logic pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Resolve special cases in priority order and pack the word.
  always_comb begin
    pk_data  = {in_sign, in_exp, in_mantissa};
    pk_flags = 3'b000;
    if (in_zero) begin
      pk_data  = {in_sign, 23'h0};
      pk_flags = F_ZERO;
    end else if (in_underflow) begin
      pk_data  = {in_sign, 23'h0};
      pk_flags = F_UNF;
    end else if (in_overflow || (in_exp == 7'h7F)) begin
      if (SAT_MODE)
        pk_data = {in_sign, 7'h7E, 16'hFFFF};
      else
        pk_data = {in_sign, 7'h7F, 16'h0000};
      pk_flags = F_OVF;
    end
  end

  // FIFO next state; head is always the oldest entry.
  always_comb begin
    head_data_d  = head_data_q;
    head_flags_d = head_flags_q;
    tail_data_d  = tail_data_q;
    tail_flags_d = tail_flags_q;
    count_d      = count_q;
    unique case (count_q)
      2'd0: begin
        if (push) begin
          head_data_d  = pk_data;
          head_flags_d = pk_flags;
          count_d      = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d  = pk_data;
          head_flags_d = pk_flags;
        end else if (push) begin
          tail_data_d  = pk_data;
          tail_flags_d = pk_flags;
          count_d      = 2'd2;
        end else if (pop) begin
          count_d      = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_data_d  = tail_data_q;
          head_flags_d = tail_flags_q;
          count_d      = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
    out_valid_d = (count_d != 2'd0);
    in_ready_d  = (count_d != 2'd2);
  end

  // Sticky flags (set beats clear) and delivered-result counter.
  always_comb begin
    sticky_ovf_d = clr_sticky ? 1'b0 : sticky_ovf_q;
    sticky_unf_d = clr_sticky ? 1'b0 : sticky_unf_q;
    if (push && pk_flags[2]) sticky_ovf_d = 1'b1;
    if (push && pk_flags[1]) sticky_unf_d = 1'b1;
    result_count_d = result_count_q;
    if (pop) result_count_d = result_count_q + CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data_q    <= '0;
      head_flags_q   <= '0;
      tail_data_q    <= '0;
      tail_flags_q   <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      in_ready_q     <= 1'b1;
      sticky_ovf_q   <= 1'b0;
      sticky_unf_q   <= 1'b0;
      result_count_q <= '0;
    end else begin
      head_data_q    <= head_data_d;
      head_flags_q   <= head_flags_d;
      tail_data_q    <= tail_data_d;
      tail_flags_q   <= tail_flags_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      in_ready_q     <= in_ready_d;
      sticky_ovf_q   <= sticky_ovf_d;
      sticky_unf_q   <= sticky_unf_d;
      result_count_q <= result_count_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign out_data         = head_data_q;
  assign out_flags        = head_flags_q;
  assign sticky_overflow  = sticky_ovf_q;
  assign sticky_underflow = sticky_unf_q;
  assign result_count     = result_count_q;

endmodule

// File: tb/tb_fmul_result_packer.sv
// Bench for fmul_result_packer: vector table + scoreboard,
// plus backpressure, sticky, mid-stream reset and wrap sequences.
module tb_fmul_result_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [6:0]  in_exp = '0;
  logic [15:0] in_mantissa = '0;
  logic        in_overflow = 1'b0;
  logic        in_underflow = 1'b0;
  logic        in_zero = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_sticky = 1'b0;

  logic        in_ready, out_valid;
  logic [23:0] out_data;
  logic [2:0]  out_flags;
  logic        sticky_overflow, sticky_underflow;
  logic [15:0] result_count;

  logic        in_ready0, out_valid0;
  logic [23:0] out_data0;
  logic [2:0]  out_flags0;
  logic        sov0, sun0;
  logic [1:0]  result_count0;

  always #5 clk = ~clk;

  fmul_result_packer #(.SAT_MODE(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp),
    .in_mantissa(in_mantissa),
    .in_overflow(in_overflow), .in_underflow(in_underflow),
    .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags),
    .clr_sticky(clr_sticky),
    .sticky_overflow(sticky_overflow),
    .sticky_underflow(sticky_underflow),
    .result_count(result_count)
  );

  fmul_result_packer #(.SAT_MODE(1'b0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_sign(in_sign), .in_exp(in_exp),
    .in_mantissa(in_mantissa),
    .in_overflow(in_overflow), .in_underflow(in_underflow),
    .in_zero(in_zero),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_flags(out_flags0),
    .clr_sticky(clr_sticky),
    .sticky_overflow(sov0),
    .sticky_underflow(sun0),
    .result_count(result_count0)
  );

  typedef struct {
    logic        s;
    logic [6:0]  e;
    logic [15:0] m;
    logic        ovf;
    logic        unf;
    logic        zero;
    logic [23:0] d1;
    logic [23:0] d0;
    logic [2:0]  f;
  } vec_t;

  typedef struct {
    logic [23:0] d1;
    logic [23:0] d0;
    logic [2:0]  f;
  } exp_t;

  vec_t tbl [11];
  exp_t sbq [$];
  exp_t cur;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(logic s, logic [6:0] e,
                              logic [15:0] m, logic ovf,
                              logic unf, logic zero,
                              logic [23:0] d1, logic [23:0] d0,
                              logic [2:0] f);
    vec_t v;
    v.s = s; v.e = e; v.m = m;
    v.ovf = ovf; v.unf = unf; v.zero = zero;
    v.d1 = d1; v.d0 = d0; v.f = f;
    return v;
  endfunction

  // Scoreboard: compare on pop, record on push, at negedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("data", {8'h0, out_data}, {8'h0, e.d1});
          chk("flags", {29'h0, out_flags}, {29'h0, e.f});
          chk("data_sat0", {8'h0, out_data0}, {8'h0, e.d0});
          chk("flags_sat0", {29'h0, out_flags0},
              {29'h0, e.f});
        end
      end
      if (in_valid && in_ready) sbq.push_back(cur);
    end
  end

  task automatic drive(vec_t v);
    in_sign = v.s;
    in_exp = v.e;
    in_mantissa = v.m;
    in_overflow = v.ovf;
    in_underflow = v.unf;
    in_zero = v.zero;
    cur.d1 = v.d1;
    cur.d0 = v.d0;
    cur.f = v.f;
  endtask

  task automatic send(vec_t v);
    int n;
    drive(v);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("drain", sbq.size(), 32'd0);
  endtask

  initial begin
    tbl[0]  = mk(0, 7'h40, 16'h8000, 0, 0, 0,
                 24'h408000, 24'h408000, 3'b000);
    tbl[1]  = mk(1, 7'h40, 16'h8000, 0, 0, 0,
                 24'hC08000, 24'hC08000, 3'b000);
    tbl[2]  = mk(1, 7'h22, 16'h1111, 0, 1, 1,
                 24'h800000, 24'h800000, 3'b001);
    tbl[3]  = mk(0, 7'h05, 16'hABCD, 0, 1, 0,
                 24'h000000, 24'h000000, 3'b010);
    tbl[4]  = mk(1, 7'h10, 16'h0F0F, 1, 0, 0,
                 24'hFEFFFF, 24'hFF0000, 3'b100);
    tbl[5]  = mk(1, 7'h7F, 16'h1234, 0, 0, 0,
                 24'hFEFFFF, 24'hFF0000, 3'b100);
    tbl[6]  = mk(0, 7'h7F, 16'h0000, 0, 0, 0,
                 24'h7EFFFF, 24'h7F0000, 3'b100);
    tbl[7]  = mk(0, 7'h00, 16'h5555, 0, 0, 0,
                 24'h005555, 24'h005555, 3'b000);
    tbl[8]  = mk(0, 7'h7F, 16'hFFFF, 1, 0, 1,
                 24'h000000, 24'h000000, 3'b001);
    tbl[9]  = mk(1, 7'h7F, 16'h2222, 1, 1, 0,
                 24'h800000, 24'h800000, 3'b010);
    tbl[10] = mk(0, 7'h3F, 16'h1234, 0, 0, 0,
                 24'h3F1234, 24'h3F1234, 3'b000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_data", {8'h0, out_data}, 32'd0);
    chk("rst_out_flags", {29'h0, out_flags}, 32'd0);
    chk("rst_sticky", {30'h0, sticky_overflow,
        sticky_underflow}, 32'd0);
    chk("rst_count", {16'h0, result_count}, 32'd0);

    // Table: back-to-back with out_ready high, so each later
    // push coincides with a pop at occupancy 1.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(tbl[i]);
      chk("latency_valid", {31'h0, out_valid}, 32'd1);
    end
    drain();
    chk("count_11", {16'h0, result_count}, 32'd11);
    chk("count_w2_11", {30'h0, result_count0}, 32'd3);
    chk("sticky_ovf_set", {31'h0, sticky_overflow}, 32'd1);
    chk("sticky_unf_set", {31'h0, sticky_underflow}, 32'd1);

    // Sticky clear, then clear colliding with overflow push.
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    chk("sticky_clr", {30'h0, sticky_overflow,
        sticky_underflow}, 32'd0);
    clr_sticky = 1'b1;
    send(tbl[4]);
    clr_sticky = 1'b0;
    chk("set_wins_ovf", {31'h0, sticky_overflow}, 32'd1);
    chk("set_wins_unf", {31'h0, sticky_underflow}, 32'd0);
    drain();
    chk("count_12", {16'h0, result_count}, 32'd12);

    // Backpressure: fill both slots, third push ignored.
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[10]);
    chk("full_in_ready", {31'h0, in_ready}, 32'd0);
    chk("full_head", {8'h0, out_data}, 32'h408000);
    drive(tbl[7]);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("hold_head", {8'h0, out_data}, 32'h408000);
    chk("hold_valid", {31'h0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_pop", {31'h0, in_ready}, 32'd1);
    chk("second_head", {8'h0, out_data}, 32'h3F1234);
    @(posedge clk); #1;
    chk("empty_after", {31'h0, out_valid}, 32'd0);
    chk("count_14", {16'h0, result_count}, 32'd14);
    chk("count_w2_14", {30'h0, result_count0}, 32'd2);

    // Reset with two entries buffered.
    out_ready = 1'b0;
    send(tbl[4]);
    send(tbl[3]);
    chk("pre_rst_valid", {31'h0, out_valid}, 32'd1);
    chk("pre_rst_sticky", {31'h0, sticky_overflow}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'h0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'h0, in_ready}, 32'd1);
    chk("mid_rst_count", {16'h0, result_count}, 32'd0);
    chk("mid_rst_sticky", {30'h0, sticky_overflow,
        sticky_underflow}, 32'd0);

    // Five deliveries: 2-bit counter wraps to 1.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(tbl[i]);
    drain();
    chk("count_5", {16'h0, result_count}, 32'd5);
    chk("wrap_w2", {30'h0, result_count0}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
